peak_scan_sched: RTL and testbench

- Scan scheduler in front of peak_doubles_shell; shares one peak detector among NCH spectrum buffers.
- Arbitrates scan requests round-robin and reads the granted channel's frame from its buffer.
- Streams the frame to the detector as valid/input_i/index_i/last, then captures the packed result (p_i_s) on last_out.
- Returns the result with the channel ID over a ready/valid handshake.

---
 rtl/peak_scan_sched.sv | 211 +++++++++++++++++++++
 tb/tb_peak_scan_sched.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/peak_scan_sched.sv
// peak_scan_sched
// Lets NCH spectrum buffers take turns using one peak detector. Scan
// requests are granted round-robin. The granted channel's frame is read
// from its buffer and streamed to the detector. The detector's packed
// result is then returned to the requester over a ready/valid handshake.
//
// Ports
//   clk, aresetn        clock, asynchronous active-low reset
//   req[NCH]            per-channel scan request (level)
//   ack[NCH]            one-cycle pulse in the cycle a result is accepted
//   rd_en/rd_ch/rd_addr buffer read port; rd_data returns RD_LAT cycles later
//   pk_valid/pk_input/pk_index/pk_last   sample stream to the detector
//   pk_last_out/pk_result                detector completion and packed result
//   res_valid/res_ready/res_data/res_ch/res_err   result handshake
//   busy                high whenever the scheduler is not idle
module peak_scan_sched #(
    parameter int NCH       = 4,
    parameter int VALUE_W   = 16,
    parameter int INDEX_W   = 15,
    parameter int FRAME_LEN = 1024,
    parameter int RD_LAT    = 2,
    parameter int TIMEOUT   = 64,
    localparam int CH_W     = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int RES_W    = VALUE_W + 1 + INDEX_W
) (
    input  logic               clk,
    input  logic               aresetn,
    input  logic [NCH-1:0]     req,
    output logic [NCH-1:0]     ack,
    output logic               rd_en,
    output logic [CH_W-1:0]    rd_ch,
    output logic [INDEX_W-1:0] rd_addr,
    input  logic [VALUE_W-1:0] rd_data,
    output logic               pk_valid,
    output logic [VALUE_W-1:0] pk_input,
    output logic [INDEX_W-1:0] pk_index,
    output logic               pk_last,
    input  logic               pk_last_out,
    input  logic [RES_W-1:0]   pk_result,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [RES_W-1:0]   res_data,
    output logic [CH_W-1:0]    res_ch,
    output logic               res_err,
    output logic               busy
);

    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [INDEX_W-1:0] LAST_ADDR = INDEX_W'(FRAME_LEN - 1);
    localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic [CH_W-1:0]    CH_LAST   = CH_W'(NCH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_WAIT_RES,
        S_OUT
    } state_t;

    state_t               state_q, state_d;
    logic [INDEX_W-1:0]   addr_q, addr_d;
    logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
    logic [CH_W-1:0]      ch_q, ch_d;
    logic [CH_W-1:0]      rr_q, rr_d;
    logic [RES_W-1:0]     res_data_q, res_data_d;
    logic                 res_err_q, res_err_d;
    logic [RD_LAT-1:0]    vld_q, vld_d;
    logic [INDEX_W-1:0]   apipe_q [RD_LAT];
    logic [INDEX_W-1:0]   apipe_d [RD_LAT];

    logic                 grant_vld;
    logic [CH_W-1:0]      grant_ch;
    logic [CH_W-1:0]      scan_idx;
    logic                 to_hit;
    logic                 accept;

    // Round-robin arbiter: first set request at or after rr_q, wrapping.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        scan_idx  = rr_q;
        for (int i = 0; i < NCH; i++) begin
            if (!grant_vld && req[scan_idx]) begin
                grant_vld = 1'b1;
                grant_ch  = scan_idx;
            end
            scan_idx = (scan_idx == CH_LAST) ? '0 : scan_idx + 1'b1;
        end
    end

    // Counter value TIMEOUT-1 means this is the TIMEOUT-th cycle waiting.
    assign to_hit = (to_cnt_q == TO_LAST);
    assign accept = (state_q == S_OUT) && res_ready;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (grant_vld) state_d = S_SCAN;
            S_SCAN:     if (addr_q == LAST_ADDR) state_d = S_DRAIN;
            S_DRAIN:    if (pk_last) state_d = S_WAIT_RES;
            S_WAIT_RES: if (pk_last_out || to_hit) state_d = S_OUT;
            S_OUT:      if (res_ready) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        rd_en     = (state_q == S_SCAN);
        busy      = (state_q != S_IDLE);
        res_valid = (state_q == S_OUT);
        ack       = '0;
        if (accept) begin
            ack[ch_q] = 1'b1;
        end
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        addr_d     = addr_q;
        to_cnt_d   = '0;
        ch_d       = ch_q;
        rr_d       = rr_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;

        if (state_q == S_IDLE && grant_vld) begin
            ch_d = grant_ch;
        end

        if (state_q == S_SCAN) begin
            addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
        end

        // Counter only runs in WAIT_RES, so it is 0 on entry.
        if (state_q == S_WAIT_RES) begin
            to_cnt_d = to_cnt_q + 1'b1;
            if (pk_last_out) begin
                res_data_d = pk_result;
                res_err_d  = 1'b0;
            end else if (to_hit) begin
                res_data_d = '0;
                res_err_d  = 1'b1;
            end
        end

        if (accept) begin
            rr_d = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
        end

        // Read strobe and address travel alongside the buffer's read latency.
        vld_d[0]   = rd_en;
        apipe_d[0] = rd_en ? addr_q : '0;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i]   = vld_q[i-1];
            apipe_d[i] = apipe_q[i-1];
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            addr_q     <= '0;
            to_cnt_q   <= '0;
            ch_q       <= '0;
            rr_q       <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
            vld_q      <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                apipe_q[i] <= '0;
            end
        end else begin
            addr_q     <= addr_d;
            to_cnt_q   <= to_cnt_d;
            ch_q       <= ch_d;
            rr_q       <= rr_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
            vld_q      <= vld_d;
            for (int i = 0; i < RD_LAT; i++) begin
                apipe_q[i] <= apipe_d[i];
            end
        end
    end

    assign rd_ch    = ch_q;
    assign rd_addr  = addr_q;
    assign res_ch   = ch_q;
    assign res_data = res_data_q;
    assign res_err  = res_err_q;

    // Read data is only forwarded alongside a valid sample so the detector
    // input is quiet (and zero under reset) between scans.
    assign pk_valid = vld_q[RD_LAT-1];
    assign pk_index = apipe_q[RD_LAT-1];
    assign pk_input = pk_valid ? rd_data : '0;
    assign pk_last  = pk_valid && (apipe_q[RD_LAT-1] == LAST_ADDR);

endmodule

// File: tb/tb_peak_scan_sched.sv
// Bench for peak_scan_sched: buffer and peak-detector models around the DUT,
// directed scans followed by randomized scans, checked against a reference
// round-robin order and a peak computed directly from the buffer contents.
module tb_peak_scan_sched;

    localparam int NCH       = 4;
    localparam int FRAME_LEN = 8;
    localparam int RD_LAT    = 2;
    localparam int TIMEOUT   = 16;
    localparam int DET_LAT   = 3;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic [3:0]  req = 4'b0;
    logic [3:0]  ack;
    logic        rd_en;
    logic [1:0]  rd_ch;
    logic [14:0] rd_addr;
    logic [15:0] rd_data;
    logic        pk_valid;
    logic [15:0] pk_input;
    logic [14:0] pk_index;
    logic        pk_last;
    logic        pk_last_out = 1'b0;
    logic [31:0] pk_result = 32'h0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic [1:0]  res_ch;
    logic        res_err;
    logic        busy;

    peak_scan_sched #(
        .NCH(NCH), .VALUE_W(16), .INDEX_W(15),
        .FRAME_LEN(FRAME_LEN), .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .aresetn(aresetn), .req(req), .ack(ack),
        .rd_en(rd_en), .rd_ch(rd_ch), .rd_addr(rd_addr), .rd_data(rd_data),
        .pk_valid(pk_valid), .pk_input(pk_input), .pk_index(pk_index),
        .pk_last(pk_last), .pk_last_out(pk_last_out), .pk_result(pk_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_ch(res_ch), .res_err(res_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_cyc = 0;
    int ack_cnt  = 0;
    int det_cnt  = 0;
    bit det_dead = 1'b0;
    logic [31:0] det_val = 32'h0;

    typedef struct { int cyc; logic [14:0] idx; logic [15:0] val; logic last; } samp_t;
    typedef struct { int cyc; logic [14:0] addr; logic [1:0] ch; } rd_t;
    samp_t sq[$];
    rd_t   rq[$];

    logic [15:0] mem [NCH][FRAME_LEN];
    logic [15:0] rpipe [RD_LAT];

    always @(posedge clk) cyc <= cyc + 1;

    // Buffer model: data for a read strobe appears RD_LAT cycles later.
    always @(posedge clk) begin
        rpipe[0] <= rd_en ? mem[rd_ch][rd_addr[2:0]] : 16'h0;
        for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign rd_data = rpipe[RD_LAT-1];

    // Peak of a frame: largest value, earliest index on ties, found flag set.
    function automatic logic [31:0] peak_of_stream();
        logic [15:0] mx = 16'h0;
        int ix = 0;
        for (int i = 0; i < sq.size(); i++)
            if (i == 0 || sq[i].val > mx) begin mx = sq[i].val; ix = i; end
        return {mx, 1'b1, 15'(ix)};
    endfunction

    function automatic logic [31:0] exp_peak(int ch);
        logic [15:0] mx = mem[ch][0];
        int ix = 0;
        for (int i = 1; i < FRAME_LEN; i++)
            if (mem[ch][i] > mx) begin mx = mem[ch][i]; ix = i; end
        return {mx, 1'b1, 15'(ix)};
    endfunction

    function automatic int exp_grant(logic [3:0] r, int ptr);
        for (int i = 0; i < NCH; i++)
            if (r[(ptr + i) % NCH]) return (ptr + i) % NCH;
        return -1;
    endfunction

    // Stream monitor and detector model, evaluated mid-cycle.
    always @(negedge clk) begin
        pk_last_out = 1'b0;
        if (!aresetn) begin
            det_cnt = 0;
        end else begin
            if (|ack) ack_cnt++;
            if (rd_en) rq.push_back('{cyc, rd_addr, rd_ch});
            if (det_cnt > 0) begin
                det_cnt--;
                if (det_cnt == 0 && !det_dead) begin
                    pk_last_out = 1'b1;
                    pk_result   = det_val;
                end
            end
            if (pk_valid) begin
                sq.push_back('{cyc, pk_index, pk_input, pk_last});
                if (pk_last) begin
                    last_cyc = cyc;
                    det_val  = peak_of_stream();
                    det_cnt  = DET_LAT;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd"}, {31'(0), rd_en} | 32'(rd_ch) | 32'(rd_addr), 32'h0);
        chk({tag, "_pk"}, {31'(0), pk_valid} | 32'(pk_input) | 32'(pk_index) | 32'(pk_last), 32'h0);
        chk({tag, "_res_valid"}, 32'(res_valid), 32'h0);
        chk({tag, "_res_data"}, res_data, 32'h0);
        chk({tag, "_res_ch_err"}, 32'(res_ch) | 32'(res_err), 32'h0);
        chk({tag, "_ack"}, 32'(ack), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    // One complete scan: grant, stream, result, handshake, stream audit.
    task automatic run_scan(input logic [3:0] reqv, input int exp_ch, input int hold,
                            input bit dead, input int drop_at, output logic [31:0] got);
        bit ok;
        int t_res;
        logic [31:0] exp_res;
        got = 32'h0;
        sq.delete();
        rq.delete();
        det_dead = dead;
        req = reqv;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (rd_en) begin ok = 1'b1; break; end
        end
        chk("grant_seen", 32'(ok), 32'h1);
        if (!ok) return;
        chk("rd_ch", 32'(rd_ch), 32'(exp_ch));
        chk("busy_scan", 32'(busy), 32'h1);
        ok = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (drop_at >= 0 && pk_valid && int'(pk_index) == drop_at) req[exp_ch] = 1'b0;
            if (res_valid) begin ok = 1'b1; break; end
            tick();
        end
        chk("res_valid_seen", 32'(ok), 32'h1);
        if (!ok) return;
        t_res = cyc;
        exp_res = dead ? 32'h0 : exp_peak(exp_ch);
        chk("res_data", res_data, exp_res);
        chk("res_err", 32'(res_err), 32'(dead));
        chk("res_ch", 32'(res_ch), 32'(exp_ch));
        if (dead) chk("timeout_latency", 32'(t_res - (last_cyc + 1)), 32'(TIMEOUT));
        got = res_data;
        for (int k = 0; k < hold; k++) begin
            res_ready = 1'b0;
            #1;
            chk("hold_valid", 32'(res_valid), 32'h1);
            chk("hold_data", res_data, exp_res);
            chk("hold_ch_rden_ack", {28'(0), ack} | 32'(res_ch) << 8 | 32'(rd_en) << 12,
                32'(exp_ch) << 8);
            tick();
        end
        res_ready = 1'b1;
        #1;
        chk("ack_pulse", 32'(ack), 32'(1) << exp_ch);
        tick();
        res_ready = 1'b0;
        #1;
        chk("res_valid_drop", 32'(res_valid), 32'h0);
        chk("ack_single", 32'(ack), 32'h0);
        chk("rd_count", 32'(rq.size()), 32'(FRAME_LEN));
        chk("pk_count", 32'(sq.size()), 32'(FRAME_LEN));
        if (rq.size() > 0 && sq.size() > 0)
            chk("pk_first_latency", 32'(sq[0].cyc - rq[0].cyc), 32'(RD_LAT));
        for (int i = 0; i < rq.size(); i++) begin
            chk("rd_addr_seq", 32'(rq[i].addr), 32'(i));
            chk("rd_contig", 32'(rq[i].cyc - rq[0].cyc), 32'(i));
        end
        for (int i = 0; i < sq.size(); i++) begin
            chk("pk_index_seq", 32'(sq[i].idx), 32'(i));
            chk("pk_input", 32'(sq[i].val), (i < FRAME_LEN) ? 32'(mem[exp_ch][i % FRAME_LEN]) : 32'hFFFF_FFFF);
            chk("pk_last", 32'(sq[i].last), 32'(i == FRAME_LEN - 1));
            chk("pk_contig", 32'(sq[i].cyc - sq[0].cyc), 32'(i));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int rr_m;
        int ch;
        int done;
        logic [31:0] got;
        logic [3:0] r;
        logic [15:0] golden [FRAME_LEN];
        bit ok;

        golden = '{16'h0004, 16'h0028, 16'h0034, 16'h0A34, 16'h0514, 16'h00C3, 16'h00C3, 16'h00C1};
        for (int c = 0; c < NCH; c++)
            for (int i = 0; i < FRAME_LEN; i++) mem[c][i] = 16'($urandom);

        // Reset state
        aresetn = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        aresetn = 1'b1;
        tick();
        rr_m = 0;
        done = 0;

        // All channels requesting for five scans: strict rotation from 0.
        for (int s = 0; s < 5; s++) begin
            ch = exp_grant(4'b1111, rr_m);
            chk("rr_order", 32'(ch), 32'(s % NCH));
            run_scan(4'b1111, ch, 0, 1'b0, -1, got);
            rr_m = (ch + 1) % NCH;
            done++;
        end

        // Known frame on channel 2.
        for (int i = 0; i < FRAME_LEN; i++) mem[2][i] = golden[i];
        ch = exp_grant(4'b0100, rr_m);
        run_scan(4'b0100, ch, 0, 1'b0, -1, got);
        chk("golden_result", got, 32'h0A34_8003);
        rr_m = (ch + 1) % NCH;
        done++;

        // Result held while the consumer stalls.
        ch = exp_grant(4'b0001, rr_m);
        run_scan(4'b0001, ch, 10, 1'b0, -1, got);
        rr_m = (ch + 1) % NCH;
        done++;

        // Request withdrawn mid-scan on channel 3.
        ch = exp_grant(4'b1000, rr_m);
        run_scan(4'b1000, ch, 0, 1'b0, 3, got);
        chk("req_dropped", 32'(req[3]), 32'h0);
        rr_m = (ch + 1) % NCH;
        done++;

        // Detector never answers.
        ch = exp_grant(4'b0100, rr_m);
        run_scan(4'b0100, ch, 2, 1'b1, -1, got);
        rr_m = (ch + 1) % NCH;
        done++;
        det_dead = 1'b0;

        // Reset in the middle of a channel-1 scan.
        req = 4'b0010;
        sq.delete();
        rq.delete();
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (pk_valid && pk_index == 15'd4) begin ok = 1'b1; break; end
        end
        chk("abort_point_seen", 32'(ok), 32'h1);
        chk("abort_rd_ch", 32'(rd_ch), 32'h1);
        aresetn = 1'b0;
        #1;
        chk_all_zero("reset_mid");
        tick();
        chk("reset_hold_ack", 32'(ack) | 32'(busy), 32'h0);
        req = 4'b1010;
        aresetn = 1'b1;
        rr_m = 0;
        ch = exp_grant(4'b1010, rr_m);
        chk("post_reset_grant_model", 32'(ch), 32'h1);
        run_scan(4'b1010, ch, 0, 1'b0, -1, got);
        rr_m = (ch + 1) % NCH;
        done++;

        // Randomized scans.
        for (int s = 0; s < 6; s++) begin
            r = 4'($urandom_range(1, 15));
            ch = exp_grant(r, rr_m);
            for (int i = 0; i < FRAME_LEN; i++) mem[ch][i] = 16'($urandom);
            run_scan(r, ch, int'($urandom_range(0, 3)), 1'b0, -1, got);
            rr_m = (ch + 1) % NCH;
            done++;
        end
        req = 4'b0;
        repeat (3) tick();
        chk("idle_at_end", 32'(busy), 32'h0);
        chk("ack_total", 32'(ack_cnt), 32'(done));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
